ntm_matrix_adder_controller: RTL and testbench

//  Sequences element-wise addition C = A + B for matrices up to MAX_I x MAX_J, in row-major order.

---
 rtl/ntm_matrix_adder_pkg.sv | 23 ++
 rtl/ntm_scalar_adder_stage.sv | 24 ++
 rtl/ntm_matrix_adder_controller.sv | 150 +++++++++++++++
 tb/tb_ntm_matrix_adder_controller.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntm_matrix_adder_pkg.sv
// Shared types and helpers for the NTM matrix adder controller.
// Pure declarations: no latency or flow control of its own.
package ntm_matrix_adder_pkg;

   localparam int DATA_SIZE_DEFAULT = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ADD,
      EMIT,
      DONE
   } state_t;

   // True when (i,j) is the bottom-right element of an si x sj matrix.
   function automatic logic last_element(input logic [31:0] i,
                                         input logic [31:0] j,
                                         input logic [31:0] si,
                                         input logic [31:0] sj);
      return (i == si - 32'd1) && (j == sj - 32'd1);
   endfunction

endpackage

// File: rtl/ntm_scalar_adder_stage.sv
// Registered unsigned adder, zero-extended sum; 1-cycle latency when en is high.
// No flow control: the caller only pulses en while the operands are stable.
module ntm_scalar_adder_stage
   import ntm_matrix_adder_pkg::*;
#(
   parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DATA_SIZE-1:0] a,
   input  logic [DATA_SIZE-1:0] b,
   output logic [DATA_SIZE:0]   sum
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum <= '0;
      end else if (en) begin
         sum <= {1'b0, a} + {1'b0, b};
      end
   end

endmodule

// File: rtl/ntm_matrix_adder_controller.sv
// Element-wise C = A + B sequencer, row-major; one element per 3 cycles (accept T, result T+2).
// Input accepted only in FETCH; result held stable in EMIT until out_ready, stalling indefinitely.
module ntm_matrix_adder_controller
   import ntm_matrix_adder_pkg::*;
#(
   parameter  int DATA_SIZE = DATA_SIZE_DEFAULT,
   parameter  int MAX_I     = 4,
   parameter  int MAX_J     = 4,
   localparam int CW        = $clog2(MAX_I + 1),
   localparam int RW        = $clog2(MAX_J + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CW-1:0]        size_i_in,
   input  logic [RW-1:0]        size_j_in,
   input  logic [DATA_SIZE-1:0] data_a_in,
   input  logic [DATA_SIZE-1:0] data_b_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [DATA_SIZE:0]   data_out,
   output logic [CW-1:0]        index_i_out,
   output logic [RW-1:0]        index_j_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 done
);

   state_t               state;
   state_t               state_nxt;
   logic [CW-1:0]        size_i_q;
   logic [RW-1:0]        size_j_q;
   logic [CW-1:0]        i_q;
   logic [RW-1:0]        j_q;
   logic [DATA_SIZE-1:0] a_q;
   logic [DATA_SIZE-1:0] b_q;
   logic [CW-1:0]        size_i_clamp;
   logic [RW-1:0]        size_j_clamp;
   logic                 zero_job;
   logic                 last;
   logic                 row_end;
   logic                 add_en;

   assign size_i_clamp = (size_i_in > CW'(MAX_I)) ? CW'(MAX_I) : size_i_in;
   assign size_j_clamp = (size_j_in > RW'(MAX_J)) ? RW'(MAX_J) : size_j_in;
   assign zero_job     = (size_i_in == '0) || (size_j_in == '0);
   assign last         = last_element(32'(i_q), 32'(j_q), 32'(size_i_q), 32'(size_j_q));
   assign row_end      = (j_q == size_j_q - RW'(1));
   assign add_en       = (state == ADD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = zero_job ? DONE : FETCH;
            end
         end
         FETCH: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_nxt = ADD;
            end
         end
         // Adder stage registers the sum during this cycle.
         ADD: begin
            state_nxt = EMIT;
         end
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = last ? DONE : FETCH;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         size_i_q <= '0;
         size_j_q <= '0;
         i_q      <= '0;
         j_q      <= '0;
         a_q      <= '0;
         b_q      <= '0;
      end else begin
         if (state == IDLE && start) begin
            size_i_q <= size_i_clamp;
            size_j_q <= size_j_clamp;
            i_q      <= '0;
            j_q      <= '0;
         end
         if (state == FETCH && in_valid) begin
            a_q <= data_a_in;
            b_q <= data_b_in;
         end
         // Indices advance only once the current result has been taken.
         if (state == EMIT && out_ready && !last) begin
            if (row_end) begin
               j_q <= '0;
               i_q <= i_q + CW'(1);
            end else begin
               j_q <= j_q + RW'(1);
            end
         end
      end
   end

   ntm_scalar_adder_stage #(
      .DATA_SIZE(DATA_SIZE)
   ) u_adder (
      .clk(clk),
      .rst(rst),
      .en (add_en),
      .a  (a_q),
      .b  (b_q),
      .sum(data_out)
   );

   assign index_i_out = i_q;
   assign index_j_out = j_q;

   a_rdy_vld_excl: assert property (@(posedge clk) disable iff (rst)
      !(in_ready && out_valid));

   a_emit_hold: assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(data_out)));

endmodule

// File: tb/tb_ntm_matrix_adder_controller.sv
// Bench for ntm_matrix_adder_controller: queue-based expected-result model plus directed literal checks.
module tb_ntm_matrix_adder_controller;

   localparam int DS = 8;
   localparam int CW = 3;
   localparam int RW = 3;

   logic          clk;
   logic          rst;
   logic          start;
   logic [CW-1:0] size_i_in;
   logic [RW-1:0] size_j_in;
   logic [DS-1:0] data_a_in;
   logic [DS-1:0] data_b_in;
   logic          in_valid;
   logic          in_ready;
   logic [DS:0]   data_out;
   logic [CW-1:0] index_i_out;
   logic [RW-1:0] index_j_out;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;

   ntm_matrix_adder_controller #(
      .DATA_SIZE(DS),
      .MAX_I    (4),
      .MAX_J    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .size_i_in  (size_i_in),
      .size_j_in  (size_j_in),
      .data_a_in  (data_a_in),
      .data_b_in  (data_b_in),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_out   (data_out),
      .index_i_out(index_i_out),
      .index_j_out(index_j_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      int d;
      int i;
      int j;
   } exp_t;

   exp_t expq[$];
   exp_t cmp_e;
   int   got_d[$];
   int   got_i[$];
   int   got_j[$];
   int   rise_q[$];
   int   n_cmp     = 0;
   int   n_err     = 0;
   int   cyc       = 0;
   int   done_cnt  = 0;
   int   out_cnt   = 0;
   int   last_xfer = 0;
   int   src_k     = 0;
   int   src_n     = 0;
   int   snk_mode  = 0;
   bit   src_rand  = 0;
   bit   chk_gap   = 0;
   bit   stall_prev = 0;
   bit   ov_prev   = 0;
   int   st_d      = 0;
   int   st_i      = 0;
   int   st_j      = 0;
   logic [7:0] job_a [16];
   logic [7:0] job_b [16];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // Operand source: presents element src_k until it is taken.
   initial begin
      in_valid  = 1'b0;
      data_a_in = '0;
      data_b_in = '0;
      forever begin
         @(negedge clk);
         if (!rst && src_k < src_n) begin
            in_valid  = src_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
            data_a_in = job_a[src_k[3:0]];
            data_b_in = job_b[src_k[3:0]];
            if (in_valid && in_ready) src_k++;
         end else begin
            in_valid = 1'b0;
         end
      end
   end

   // Result sink and per-cycle comparison against the expected queue.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_prev = 0;
            ov_prev    = 0;
            out_ready  = 1'b0;
         end else begin
            case (snk_mode)
               0:       out_ready = 1'b1;
               1:       out_ready = ($urandom_range(0, 3) != 0);
               default: out_ready = 1'b0;
            endcase
            chk("rdy_vld_excl", int'(in_ready && out_valid), 0);
            if (stall_prev) begin
               chk("stall_valid", int'(out_valid), 1);
               chk("stall_data", int'(data_out), st_d);
               chk("stall_i", int'(index_i_out), st_i);
               chk("stall_j", int'(index_j_out), st_j);
            end
            if (out_valid && out_ready) begin
               if (expq.size() == 0) begin
                  fail("unexpected_output");
               end else begin
                  cmp_e = expq.pop_front();
                  chk("sum", int'(data_out), cmp_e.d);
                  chk("index_i", int'(index_i_out), cmp_e.i);
                  chk("index_j", int'(index_j_out), cmp_e.j);
               end
               got_d.push_back(int'(data_out));
               got_i.push_back(int'(index_i_out));
               got_j.push_back(int'(index_j_out));
               last_xfer = cyc;
               out_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            st_d = int'(data_out);
            st_i = int'(index_i_out);
            st_j = int'(index_j_out);
            if (out_valid && !ov_prev) rise_q.push_back(cyc);
            ov_prev = out_valid;
            if (done) begin
               done_cnt++;
               chk("done_drained", expq.size(), 0);
               if (chk_gap) chk("done_gap", cyc - last_xfer, 1);
            end
         end
      end
   end

   task automatic start_job(input int si, input int sj, input bit gap);
      int ci;
      int cj;
      ci = (si > 4) ? 4 : si;
      cj = (sj > 4) ? 4 : sj;
      for (int k = 0; k < ci * cj; k++) begin
         exp_t e;
         e.d = int'(job_a[k[3:0]]) + int'(job_b[k[3:0]]);
         e.i = k / cj;
         e.j = k % cj;
         expq.push_back(e);
      end
      got_d.delete();
      got_i.delete();
      got_j.delete();
      rise_q.delete();
      chk_gap   = gap;
      src_k     = 0;
      src_n     = ci * cj;
      start     = 1'b1;
      size_i_in = CW'(si);
      size_j_in = RW'(sj);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_out_valid();
      int n;
      n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!out_valid) fail("timeout_out_valid");
   endtask

   task automatic wait_done(input int budget, input bit poke_busy, input bit poke_done);
      int n;
      int d0;
      n  = 0;
      d0 = done_cnt;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         if (poke_busy && n == 8) begin
            start     = 1'b1;
            size_i_in = 3'd1;
            size_j_in = 3'd1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (!done) begin
         fail("timeout_done");
         return;
      end
      if (poke_done) begin
         start     = 1'b1;
         size_i_in = 3'd2;
         size_j_in = 3'd2;
      end
      @(negedge clk);
      start = 1'b0;
      chk("idle_busy", int'(busy), 0);
      @(negedge clk);
      chk("idle_busy_2", int'(busy), 0);
      chk("done_once", done_cnt - d0, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_d [4];
      int exp_i [4];
      int exp_j [4];
      int sc;
      int dseen;
      int dc;
      int o0;
      bit ir_seen;

      rst       = 1'b1;
      start     = 1'b0;
      size_i_in = '0;
      size_j_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_data", int'(data_out), 0);
      chk("rst_idx_i", int'(index_i_out), 0);
      chk("rst_idx_j", int'(index_j_out), 0);
      rst = 1'b0;
      @(negedge clk);

      // 2x2 job, sinks always ready
      exp_d = '{11, 22, 33, 44};
      exp_i = '{0, 0, 1, 1};
      exp_j = '{0, 1, 0, 1};
      for (int k = 0; k < 4; k++) begin
         job_a[k] = 8'((k + 1));
         job_b[k] = 8'((k + 1) * 10);
      end
      snk_mode = 0;
      src_rand = 0;
      start_job(2, 2, 1);
      chk("t2_busy", int'(busy), 1);
      wait_done(200, 0, 0);
      chk("t2_count", got_d.size(), 4);
      for (int k = 0; k < 4 && k < got_d.size(); k++) begin
         chk("t2_lit_data", got_d[k], exp_d[k]);
         chk("t2_lit_i", got_i[k], exp_i[k]);
         chk("t2_lit_j", got_j[k], exp_j[k]);
      end
      chk("t2_rises", rise_q.size(), 4);
      for (int k = 1; k < rise_q.size(); k++) chk("t2_rise_gap", rise_q[k] - rise_q[k-1], 3);

      // 1x1 overflow
      job_a[0] = 8'd255;
      job_b[0] = 8'd255;
      start_job(1, 1, 1);
      wait_done(100, 0, 0);
      chk("t3_count", got_d.size(), 1);
      if (got_d.size() > 0) chk("t3_lit_510", got_d[0], 510);

      // backpressure: hold out_ready low for 5 cycles in EMIT
      job_a[0] = 8'd100; job_b[0] = 8'd50;
      job_a[1] = 8'd7;   job_b[1] = 8'd9;
      snk_mode = 2;
      start_job(1, 2, 1);
      wait_out_valid();
      for (int k = 0; k < 5; k++) begin
         chk("t4_valid", int'(out_valid), 1);
         chk("t4_data", int'(data_out), 150);
         chk("t4_idx_i", int'(index_i_out), 0);
         chk("t4_idx_j", int'(index_j_out), 0);
         chk("t4_in_ready", int'(in_ready), 0);
         @(negedge clk);
      end
      snk_mode = 0;
      wait_done(200, 0, 0);
      chk("t4_count", got_d.size(), 2);
      if (got_d.size() == 2) chk("t4_second", got_d[1], 16);

      // reset in the middle of EMIT
      for (int k = 0; k < 4; k++) begin
         job_a[k] = 8'($urandom_range(0, 255));
         job_b[k] = 8'($urandom_range(0, 255));
      end
      snk_mode = 2;
      start_job(2, 2, 0);
      wait_out_valid();
      rst   = 1'b1;
      src_n = 0;
      #1;
      chk("t1_in_ready", int'(in_ready), 0);
      chk("t1_out_valid", int'(out_valid), 0);
      chk("t1_busy", int'(busy), 0);
      chk("t1_done", int'(done), 0);
      chk("t1_data", int'(data_out), 0);
      chk("t1_idx_i", int'(index_i_out), 0);
      chk("t1_idx_j", int'(index_j_out), 0);
      expq.delete();
      @(negedge clk);
      @(negedge clk);
      rst      = 1'b0;
      snk_mode = 0;
      dc       = done_cnt;
      repeat (4) @(negedge clk);
      chk("t1_idle_busy", int'(busy), 0);
      chk("t1_idle_in_ready", int'(in_ready), 0);
      chk("t1_no_done", done_cnt - dc, 0);

      // zero-size job
      chk_gap   = 0;
      dc        = done_cnt;
      start     = 1'b1;
      size_i_in = 3'd3;
      size_j_in = 3'd0;
      sc        = cyc;
      ir_seen   = 0;
      dseen     = -1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (in_ready) ir_seen = 1;
         if (done && dseen < 0) dseen = cyc - sc;
      end
      chk("t5_in_ready", int'(ir_seen), 0);
      chk("t5_done_cnt", done_cnt - dc, 1);
      chk("t5_done_time", int'(dseen >= 1 && dseen <= 2), 1);
      chk("t5_busy_after", int'(busy), 0);

      // random 4x4 (rows requested as 7, clamped), random gaps, start pokes
      for (int k = 0; k < 16; k++) begin
         job_a[k] = 8'($urandom_range(0, 255));
         job_b[k] = 8'($urandom_range(0, 255));
      end
      snk_mode = 1;
      src_rand = 1;
      o0       = out_cnt;
      start_job(7, 4, 1);
      wait_done(3000, 1, 1);
      chk("t6_outputs", out_cnt - o0, 16);
      chk("t6_queue_empty", expq.size(), 0);
      snk_mode = 0;
      src_rand = 0;
      repeat (3) @(negedge clk);
      chk("t6_idle_in_ready", int'(in_ready), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
